// File: rtl/aes_inv_mixcols_seq.sv
// Sequential AES InvMixColumns: one 128-bit state per handshake, COLS_PER_CYCLE columns per clock.
// Optional macro AES_MIXCOL_FWD_EN adds a fwd input that selects forward MixColumns per state.

module aes_gf_mul_const #(
  parameter logic [7:0] K = 8'h09
) (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] p;

  // Shift-and-add over the constant's set bits, reducing by 0x11b at each doubling.
  always_comb begin
    y = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (K[i]) y = y ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
  end
endmodule

module aes_inv_mixcols_col (
  input  logic [31:0] col_in,
`ifdef AES_MIXCOL_FWD_EN
  output logic [31:0] fwd_out,
`endif
  output logic [31:0] inv_out
);
  logic [7:0] a  [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar r = 0; r < 4; r++) begin : g_lane
    assign a[r] = col_in[31-8*r -: 8];
    aes_gf_mul_const #(.K(8'h09)) u_m9 (.a(a[r]), .y(m9[r]));
    aes_gf_mul_const #(.K(8'h0b)) u_mb (.a(a[r]), .y(mb[r]));
    aes_gf_mul_const #(.K(8'h0d)) u_md (.a(a[r]), .y(md[r]));
    aes_gf_mul_const #(.K(8'h0e)) u_me (.a(a[r]), .y(me[r]));
    // Row r sees the coefficient row {e,b,d,9} rotated right by r.
    assign inv_out[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
`ifdef AES_MIXCOL_FWD_EN
    assign fwd_out[31-8*r -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4]
                                ^ a[(r+2)%4] ^ a[(r+3)%4];
`endif
  end

`ifdef AES_MIXCOL_FWD_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
`endif
endmodule

module aes_inv_mixcols_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef AES_MIXCOL_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never drops without a transfer and the payload is held stable while valid waits.
  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] res_q, res_d;
  logic         out_valid_q, out_valid_d;
`ifdef AES_MIXCOL_FWD_EN
  logic         mode_q, mode_d;
`endif

  logic [31:0] work_col [4];
  logic [1:0]  col_idx  [COLS_PER_CYCLE];
  logic [31:0] col_res  [COLS_PER_CYCLE];
  logic        accept;

  for (genvar c = 0; c < 4; c++) begin : g_work_col
    assign work_col[c] = work_q[127-32*c -: 32];
  end

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    logic [31:0] inv_col;
    assign col_idx[j] = col_cnt_q + 2'(j);
`ifdef AES_MIXCOL_FWD_EN
    logic [31:0] fwd_col;
    aes_inv_mixcols_col u_col (.col_in(work_col[col_idx[j]]), .fwd_out(fwd_col), .inv_out(inv_col));
    assign col_res[j] = mode_q ? fwd_col : inv_col;
`else
    aes_inv_mixcols_col u_col (.col_in(work_col[col_idx[j]]), .inv_out(inv_col));
    assign col_res[j] = inv_col;
`endif
  end

  // DONE may hand off and accept in the same cycle, so ready follows out_ready there.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_state = res_q;

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    work_d      = work_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
`ifdef AES_MIXCOL_FWD_EN
    mode_d      = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d    = in_state;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
`ifdef AES_MIXCOL_FWD_EN
          mode_d    = fwd;
`endif
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          for (int c = 0; c < 4; c++) begin
            if (col_idx[j] == 2'(c)) res_d[127-32*c -: 32] = col_res[j];
          end
        end
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST) begin
          col_cnt_d   = 2'd0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (in_valid) begin
            work_d    = in_state;
            col_cnt_d = 2'd0;
            state_d   = BUSY;
`ifdef AES_MIXCOL_FWD_EN
            mode_d    = fwd;
`endif
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      work_q      <= 128'h0;
      res_q       <= 128'h0;
      out_valid_q <= 1'b0;
`ifdef AES_MIXCOL_FWD_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
`ifdef AES_MIXCOL_FWD_EN
      mode_q      <= mode_d;
`endif
    end
  end
endmodule

// File: tb/tb_aes_inv_mixcols_seq.sv
// Directed bench for aes_inv_mixcols_seq: three instances (1, 2 and 4 columns per cycle)
// on a shared clock and reset; inputs are driven and outputs sampled on the falling edge.
module tb_aes_inv_mixcols_seq;
  logic         clk;
  logic         rst_n;
  logic         in_valid_v  [3];
  logic         in_ready_w  [3];
  logic [127:0] in_state_v  [3];
  logic         out_valid_w [3];
  logic         out_ready_v [3];
  logic [127:0] out_state_w [3];
`ifdef AES_MIXCOL_FWD_EN
  logic         fwd_v       [3];
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] ST_COL0 = 128'h8e4da1bc_01010101_01010101_01010101;
  localparam logic [127:0] EX_COL0 = 128'hdb135345_01010101_01010101_01010101;
  localparam logic [127:0] ST_FULL = 128'h9fdc589d_8e4da1bc_d5d5d7d6_c6c6c6c6;
  localparam logic [127:0] EX_FULL = 128'hf20a225c_db135345_d4d4d4d5_c6c6c6c6;
  localparam logic [127:0] ST_ALT  = 128'h4d7ebdf8_01010101_c6c6c6c6_8e4da1bc;
  localparam logic [127:0] EX_ALT  = 128'h2d26314c_01010101_c6c6c6c6_db135345;

  aes_inv_mixcols_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .in_state(in_state_v[0]),
`ifdef AES_MIXCOL_FWD_EN
    .fwd(fwd_v[0]),
`endif
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]), .out_state(out_state_w[0]));

  aes_inv_mixcols_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .in_state(in_state_v[1]),
`ifdef AES_MIXCOL_FWD_EN
    .fwd(fwd_v[1]),
`endif
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]), .out_state(out_state_w[1]));

  aes_inv_mixcols_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .in_state(in_state_v[2]),
`ifdef AES_MIXCOL_FWD_EN
    .fwd(fwd_v[2]),
`endif
    .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]), .out_state(out_state_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Latency is counted in cycles: the accept cycle is cycle 0 and each later cycle adds one,
  // so a design with 4/N busy cycles raises out_valid in cycle 4/N+1.
  task automatic run_op(input int d, input logic [127:0] st, input logic [127:0] exp,
                        input int lat_exp, input string nm);
    int lat;
    total++;
    if (in_ready_w[d] !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: in_ready=%b want 1", nm, in_ready_w[d]);
    end
    in_state_v[d]  = st;
    in_valid_v[d]  = 1'b1;
    out_ready_v[d] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid_v[d] = 1'b0;
      in_state_v[d] = rand128();
`ifdef AES_MIXCOL_FWD_EN
      fwd_v[d] = 1'($urandom_range(0, 1));
`endif
    end while (!out_valid_w[d] && lat < 20);
    total++;
    if (lat !== lat_exp) begin
      bad++;
      $display("FAIL %s_latency: got %0d cycles want %0d", nm, lat, lat_exp);
    end
    total++;
    if (out_state_w[d] !== exp) begin
      bad++;
      $display("FAIL %s_data: got %h want %h", nm, out_state_w[d], exp);
    end
    @(negedge clk);
    total++;
    if (out_valid_w[d] !== 1'b0 || in_ready_w[d] !== 1'b1) begin
      bad++;
      $display("FAIL %s_handoff: out_valid=%b in_ready=%b want 0/1", nm, out_valid_w[d], in_ready_w[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_v[d]  = 1'b0;
      in_state_v[d]  = 128'h0;
      out_ready_v[d] = 1'b0;
`ifdef AES_MIXCOL_FWD_EN
      fwd_v[d] = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (in_ready_w[d] !== 1'b1 || out_valid_w[d] !== 1'b0 || out_state_w[d] !== 128'h0) begin
        bad++;
        $display("FAIL reset_dut%0d: in_ready=%b out_valid=%b out_state=%h want 1/0/0",
                 d, in_ready_w[d], out_valid_w[d], out_state_w[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_column();
    run_op(0, ST_COL0, EX_COL0, 5, "col0_n1");
  endtask

  task automatic test_full_state();
    run_op(0, ST_FULL, EX_FULL, 5, "full_n1");
    run_op(1, ST_FULL, EX_FULL, 3, "full_n2");
    run_op(2, ST_FULL, EX_FULL, 2, "full_n4");
    run_op(1, ST_ALT,  EX_ALT,  3, "alt_n2");
    run_op(2, 128'h0,  128'h0,  2, "zero_n4");
  endtask

  task automatic test_backpressure();
    int lat;
    in_state_v[0]  = ST_FULL;
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_state_v[0] = rand128();
    end while (!out_valid_w[0] && lat < 20);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL bp_latency: got %0d cycles want 5", lat);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0 || out_state_w[0] !== EX_FULL) begin
        bad++;
        $display("FAIL bp_stall%0d: out_valid=%b in_ready=%b out_state=%h want 1/0/%h",
                 i, out_valid_w[0], in_ready_w[0], out_state_w[0], EX_FULL);
      end
      @(negedge clk);
      in_state_v[0] = rand128();
    end
    in_state_v[0]  = ST_ALT;
    out_ready_v[0] = 1'b1;
    #1;
    total++;
    if (in_ready_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_ready_on_release: in_ready=%b want 1", in_ready_w[0]);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid_v[0] = 1'b0;
      in_state_v[0] = rand128();
    end while (!out_valid_w[0] && lat < 20);
    total++;
    if (lat !== 5 || out_state_w[0] !== EX_ALT) begin
      bad++;
      $display("FAIL bp_next: got %0d cycles data %h want 5 cycles data %h", lat, out_state_w[0], EX_ALT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] sts  [3];
    logic [127:0] exps [3];
    int lat;
    sts[0] = ST_FULL;  exps[0] = EX_FULL;
    sts[1] = ST_ALT;   exps[1] = EX_ALT;
    sts[2] = ST_COL0;  exps[2] = EX_COL0;
    out_ready_v[2] = 1'b1;
    in_valid_v[2]  = 1'b1;
    in_state_v[2]  = sts[0];
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      @(negedge clk);
      lat++;
      in_valid_v[2] = (k < 2);
      in_state_v[2] = (k < 2) ? sts[k+1] : rand128();
      while (!out_valid_w[2] && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      total++;
      if (lat !== 2 || out_state_w[2] !== exps[k]) begin
        bad++;
        $display("FAIL b2b_%0d: got %0d cycles data %h want 2 cycles data %h", k, lat, out_state_w[2], exps[k]);
      end
    end
    @(negedge clk);
    total++;
    if (out_valid_w[2] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: out_valid=%b want 0", out_valid_w[2]);
    end
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    in_state_v[0]  = ST_FULL;
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_async: out_valid=%b in_ready=%b want 0/1", out_valid_w[0], in_ready_w[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_w[0] !== 1'b0) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL rst_mid_no_output: saw %0d out_valid cycles want 0", pulses);
    end
    run_op(0, ST_ALT, EX_ALT, 5, "after_rst_n1");
  endtask

`ifdef AES_MIXCOL_FWD_EN
  task automatic test_fwd_mode();
    fwd_v[0] = 1'b1;
    run_op(0, EX_COL0, ST_COL0, 5, "fwd_col0");
    fwd_v[0] = 1'b1;
    run_op(0, EX_FULL, ST_FULL, 5, "fwd_full");
    fwd_v[0] = 1'b0;
    run_op(0, ST_COL0, EX_COL0, 5, "inv_after_fwd");
    fwd_v[2] = 1'b1;
    run_op(2, EX_ALT, ST_ALT, 2, "fwd_alt_n4");
  endtask
`endif

  initial begin
    test_reset();
    test_single_column();
    test_full_state();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
`ifdef AES_MIXCOL_FWD_EN
    test_fwd_mode();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
